// File: rtl/image_buffer_pkg.sv
// Shared types and helpers for the double-buffered input-image store.
package image_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest pixel or word the expansion helper handles.
  localparam int EXPAND_W = 64;

  // Sized to encode n itself, so an out-of-range request is always expressible.
  function automatic int addr_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [EXPAND_W-1:0] expand_pixel(input logic [EXPAND_W-1:0] pix,
                                                       input bit binarize);
    if (binarize) return {{(EXPAND_W-1){1'b0}}, |pix};
    return pix;
  endfunction

endpackage

// File: rtl/image_buffer_if.sv
// Load and read bus of image_buffer, plus the FSM state for observation.
interface image_buffer_if
  import image_buffer_pkg::*;
#(
  parameter int NUM_PIXELS = 784,
  parameter int PIXEL_W    = 1,
  parameter int DATA_W     = 32
);
  localparam int ADDR_W = addr_w(NUM_PIXELS);

  // Load: load_start is taken only while load_busy=0 and load_done=0 (IDLE);
  // pixel_data is captured that same cycle, and load_done pulses once when the
  // new image becomes active. Read: rd_en/rd_addr are accepted every cycle with
  // no back-pressure; rd_valid marks the result exactly one cycle later.
  logic                          load_start;
  logic [NUM_PIXELS*PIXEL_W-1:0] pixel_data;
  logic                          rd_en;
  logic [ADDR_W-1:0]             rd_addr;
  logic                          load_busy;
  logic                          load_done;
  logic                          img_valid;
  logic                          active_bank;
  logic [DATA_W-1:0]             rd_data;
  logic                          rd_valid;
  logic                          rd_err;
  state_t                        state_dbg;

  modport master (
    output load_start, pixel_data, rd_en, rd_addr,
    input  load_busy, load_done, img_valid, active_bank, rd_data, rd_valid, rd_err,
           state_dbg
  );

  modport slave (
    input  load_start, pixel_data, rd_en, rd_addr,
    output load_busy, load_done, img_valid, active_bank, rd_data, rd_valid, rd_err,
           state_dbg
  );

endinterface

// File: rtl/image_bank.sv
// One image bank: beat-indexed multi-pixel write port and a registered read port.
module image_bank
  import image_buffer_pkg::*;
#(
  parameter int NUM_PIXELS    = 784,
  parameter int DATA_W        = 32,
  parameter int PIX_PER_CYCLE = 1,
  localparam int ADDR_W = addr_w(NUM_PIXELS),
  localparam int BEAT_W = addr_w(NUM_PIXELS / PIX_PER_CYCLE)
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [BEAT_W-1:0]               wr_beat,
  input  logic [PIX_PER_CYCLE*DATA_W-1:0] wr_data,
  input  logic                            rd_en,
  input  logic [ADDR_W-1:0]               rd_addr,
  output logic [DATA_W-1:0]               rd_data
);

  logic [DATA_W-1:0] mem_q [NUM_PIXELS];
  logic [DATA_W-1:0] mem_d [NUM_PIXELS];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Constant-index loops keep every select in range; the read holds when idle.
  always_comb begin
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      if (wr_en && wr_beat == BEAT_W'(i / PIX_PER_CYCLE))
        mem_d[i] = wr_data[(i % PIX_PER_CYCLE)*DATA_W +: DATA_W];
      if (rd_en && rd_addr == ADDR_W'(i))
        rd_data_d = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    mem_q     <= mem_d;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/image_buffer.sv
// Double-buffered image store: loads fill the inactive bank, then roles swap.
module image_buffer
  import image_buffer_pkg::*;
#(
  parameter int NUM_PIXELS    = 784,
  parameter int PIXEL_W       = 1,
  parameter int DATA_W        = 32,
  parameter int PIX_PER_CYCLE = 1,
  parameter int BINARIZE      = 0
) (
  input  logic           clk,
  input  logic           reset,
  image_buffer_if.slave  bus
);

  localparam int ADDR_W    = addr_w(NUM_PIXELS);
  localparam int NUM_BEATS = NUM_PIXELS / PIX_PER_CYCLE;
  localparam int BEAT_W    = addr_w(NUM_BEATS);
  localparam int IMG_W     = NUM_PIXELS * PIXEL_W;
  localparam int WR_W      = PIX_PER_CYCLE * DATA_W;

  if ((NUM_PIXELS % PIX_PER_CYCLE) != 0 || PIXEL_W > EXPAND_W || DATA_W > EXPAND_W)
  begin : g_param_check
    $error("image_buffer: unsupported NUM_PIXELS/PIX_PER_CYCLE/PIXEL_W/DATA_W combination");
  end

  state_t                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [IMG_W-1:0]       shadow_q, shadow_d;
  logic                   active_q, active_d;
  logic [1:0]             bank_valid_q, bank_valid_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_err_q, rd_err_d;
  logic                   rd_zero_q, rd_zero_d;
  logic                   rd_sel_q, rd_sel_d;
  logic                   in_range;
  logic                   active_view;
  logic [WR_W-1:0]        wr_data;
  logic [1:0]             bank_wr_en, bank_rd_en;
  logic [1:0][DATA_W-1:0] bank_rd_data;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    bank_valid_d = bank_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          shadow_d                = bus.pixel_data;
          beat_d                  = '0;
          bank_valid_d[~active_q] = 1'b0;
          state_d                 = LOAD;
        end
      end
      LOAD: begin
        if (beat_q == BEAT_W'(NUM_BEATS - 1)) begin
          bank_valid_d[~active_q] = 1'b1;
          state_d                 = DONE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      DONE: begin
        active_d = ~active_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pixels belonging to the current beat, expanded to stored words.
  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NUM_PIXELS; i++) begin
      if (beat_q == BEAT_W'(i / PIX_PER_CYCLE))
        wr_data[(i % PIX_PER_CYCLE)*DATA_W +: DATA_W] =
          DATA_W'(expand_pixel(EXPAND_W'(shadow_q[i*PIXEL_W +: PIXEL_W]), BINARIZE != 0));
    end
  end

  // Reads use active_q, which only flips after DONE, so a DONE-cycle read sees the old bank.
  always_comb begin
    in_range   = (bus.rd_addr < ADDR_W'(NUM_PIXELS));
    rd_valid_d = bus.rd_en;
    rd_err_d   = bus.rd_en & ~in_range;
    rd_zero_d  = rd_zero_q;
    rd_sel_d   = rd_sel_q;
    if (bus.rd_en) begin
      rd_zero_d = ~in_range | ~bank_valid_q[active_q];
      rd_sel_d  = active_q;
    end
    bank_rd_en             = '0;
    bank_rd_en[active_q]   = bus.rd_en & in_range & bank_valid_q[active_q];
    bank_wr_en             = '0;
    bank_wr_en[~active_q]  = (state_q == LOAD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      active_q     <= 1'b0;
      bank_valid_q <= '0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
      rd_zero_q    <= 1'b1;
      rd_sel_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      active_q     <= active_d;
      bank_valid_q <= bank_valid_d;
      rd_valid_q   <= rd_valid_d;
      rd_err_q     <= rd_err_d;
      rd_zero_q    <= rd_zero_d;
      rd_sel_q     <= rd_sel_d;
    end
  end

  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    image_bank #(
      .NUM_PIXELS    (NUM_PIXELS),
      .DATA_W        (DATA_W),
      .PIX_PER_CYCLE (PIX_PER_CYCLE)
    ) u_bank (
      .clk     (clk),
      .wr_en   (bank_wr_en[b]),
      .wr_beat (beat_q),
      .wr_data (wr_data),
      .rd_en   (bank_rd_en[b]),
      .rd_addr (bus.rd_addr),
      .rd_data (bank_rd_data[b])
    );
  end

  // The reported bank flips in the DONE cycle, one cycle ahead of the read-side swap.
  assign active_view     = active_q ^ (state_q == DONE);
  assign bus.active_bank = active_view;
  assign bus.img_valid   = bank_valid_q[active_view];
  assign bus.load_busy   = (state_q == LOAD);
  assign bus.load_done   = (state_q == DONE);
  assign bus.rd_data     = rd_zero_q ? '0 : bank_rd_data[rd_sel_q];
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_err      = rd_err_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_image_buffer.sv
// Directed bench for image_buffer: a 16x4-bit/4-per-beat instance and a binarizing 1-per-beat one.
module tb_image_buffer;
  import image_buffer_pkg::*;

  localparam int NP = 16;
  localparam int PW = 4;
  localparam int DW = 32;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic        err;
  } rd_vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  image_buffer_if #(.NUM_PIXELS(NP), .PIXEL_W(PW), .DATA_W(DW)) a_if ();
  image_buffer_if #(.NUM_PIXELS(NP), .PIXEL_W(PW), .DATA_W(DW)) b_if ();

  image_buffer #(.NUM_PIXELS(NP), .PIXEL_W(PW), .DATA_W(DW), .PIX_PER_CYCLE(4), .BINARIZE(0))
    dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));

  image_buffer #(.NUM_PIXELS(NP), .PIXEL_W(PW), .DATA_W(DW), .PIX_PER_CYCLE(1), .BINARIZE(1))
    dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [63:0] cur_img;
  bit          cur_valid;
  bit          cur_bank;
  rd_vec_t     tbl [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] old_pix(input int a);
    if (!cur_valid) return 32'd0;
    return 32'(cur_img[a*PW +: PW]);
  endfunction

  task automatic do_read(input logic [4:0] addr, output logic [31:0] d, output logic v,
                         output logic e);
    a_if.rd_en   = 1'b1;
    a_if.rd_addr = addr;
    step();
    a_if.rd_en = 1'b0;
    d = a_if.rd_data;
    v = a_if.rd_valid;
    e = a_if.rd_err;
  endtask

  // Load on dut_a, checking handshake timing cycle by cycle while reading the old image.
  task automatic run_load(input logic [63:0] img, input bit glitch);
    bit old_bank;
    bit exp_active;
    bit exp_valid;
    old_bank          = cur_bank;
    a_if.pixel_data   = img;
    a_if.load_start   = 1'b1;
    step();
    a_if.load_start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      exp_active = (k >= 5) ? !old_bank : old_bank;
      exp_valid  = (k >= 5) ? 1'b1 : cur_valid;
      if (k >= 2 && k <= 6) begin
        check("load_rd_valid", a_if.rd_valid, 1);
        check("load_rd_old_data", a_if.rd_data, old_pix(k - 1));
      end
      check("load_busy", a_if.load_busy, (k <= 4));
      check("load_done", a_if.load_done, (k == 5));
      check("active_bank", a_if.active_bank, exp_active);
      check("img_valid", a_if.img_valid, exp_valid);
      if (k == 7) begin
        check("rd_idle_valid", a_if.rd_valid, 0);
        check("rd_idle_hold", a_if.rd_data, old_pix(5));
      end
      if (glitch && k == 1) a_if.pixel_data = ~img;
      if (glitch && k == 2) a_if.load_start = 1'b1;
      if (k == 3) a_if.load_start = 1'b0;
      a_if.rd_en   = (k <= 5);
      a_if.rd_addr = 5'(k);
      if (k < 7) step();
    end
    a_if.rd_en = 1'b0;
    cur_img    = img;
    cur_valid  = 1'b1;
    cur_bank   = !old_bank;
  endtask

  task automatic read_sweep();
    a_if.rd_en = 1'b1;
    for (int i = 0; i < NP; i++) begin
      a_if.rd_addr = 5'(i);
      exp_q.push_back(32'(cur_img[i*PW +: PW]));
      step();
      check("sweep_valid", a_if.rd_valid, 1);
      check("sweep_data", a_if.rd_data, exp_q.pop_front());
    end
    a_if.rd_en = 1'b0;
  endtask

  task automatic apply_table(input bit second);
    logic [31:0] d;
    logic        v;
    logic        e;
    for (int i = 0; i < 8; i++) begin
      do_read(tbl[i].addr, d, v, e);
      check("tbl_valid", v, 1);
      check("tbl_err", e, tbl[i].err);
      check("tbl_data", d, second ? tbl[i].exp2 : tbl[i].exp1);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        v;
    logic        e;
    logic [63:0] img_b;
    logic [15:0] bin_exp;

    tbl[0] = '{5'd0,  32'd0,  32'd15, 1'b0};
    tbl[1] = '{5'd1,  32'd1,  32'd14, 1'b0};
    tbl[2] = '{5'd5,  32'd5,  32'd10, 1'b0};
    tbl[3] = '{5'd10, 32'd10, 32'd5,  1'b0};
    tbl[4] = '{5'd14, 32'd14, 32'd1,  1'b0};
    tbl[5] = '{5'd15, 32'd15, 32'd0,  1'b0};
    tbl[6] = '{5'd16, 32'd0,  32'd0,  1'b1};
    tbl[7] = '{5'd31, 32'd0,  32'd0,  1'b1};
    img_b   = 64'h10C0_7003_0802_F910;
    bin_exp = 16'hA95E;

    cur_img   = '0;
    cur_valid = 1'b0;
    cur_bank  = 1'b0;
    reset     = 1'b1;
    a_if.load_start = 1'b0; a_if.pixel_data = '0; a_if.rd_en = 1'b0; a_if.rd_addr = '0;
    b_if.load_start = 1'b0; b_if.pixel_data = '0; b_if.rd_en = 1'b0; b_if.rd_addr = '0;
    repeat (3) step();
    reset = 1'b0;

    check("rst_load_busy", a_if.load_busy, 0);
    check("rst_load_done", a_if.load_done, 0);
    check("rst_img_valid", a_if.img_valid, 0);
    check("rst_active_bank", a_if.active_bank, 0);
    check("rst_rd_valid", a_if.rd_valid, 0);
    check("rst_rd_err", a_if.rd_err, 0);
    check("rst_rd_data", a_if.rd_data, 0);
    check("rst_state", 32'(a_if.state_dbg), 32'(IDLE));

    do_read(5'd3, d, v, e);
    check("empty_rd_valid", v, 1);
    check("empty_rd_data", d, 0);
    check("empty_rd_err", e, 0);
    check("empty_img_valid", a_if.img_valid, 0);
    check("empty_active_bank", a_if.active_bank, 0);

    run_load(64'hFEDC_BA98_7654_3210, 1'b0);
    read_sweep();
    apply_table(1'b0);

    run_load(64'h0123_4567_89AB_CDEF, 1'b1);
    apply_table(1'b1);
    read_sweep();

    // Abort a load at beat 2: nothing may swap afterwards.
    a_if.pixel_data = 64'hFEDC_BA98_7654_3210;
    a_if.load_start = 1'b1;
    step();
    a_if.load_start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_state", 32'(a_if.state_dbg), 32'(IDLE));
    check("abort_busy", a_if.load_busy, 0);
    check("abort_img_valid", a_if.img_valid, 0);
    check("abort_active_bank", a_if.active_bank, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("abort_no_done", a_if.load_done, 0);
      check("abort_no_swap", a_if.active_bank, 0);
    end

    b_if.pixel_data = img_b;
    b_if.load_start = 1'b1;
    step();
    b_if.load_start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      check("bin_load_busy", b_if.load_busy, (k <= 16));
      check("bin_load_done", b_if.load_done, (k == 17));
      if (k < 18) step();
    end
    check("bin_img_valid", b_if.img_valid, 1);
    check("bin_active_bank", b_if.active_bank, 1);
    b_if.rd_en = 1'b1;
    for (int i = 0; i < NP; i++) begin
      b_if.rd_addr = 5'(i);
      exp_q.push_back(32'(bin_exp[i]));
      step();
      check("bin_rd_valid", b_if.rd_valid, 1);
      check("bin_rd_data", b_if.rd_data, exp_q.pop_front());
    end
    b_if.rd_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
